// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game engine.
// Cell index convention: x*GRID_SIZE+y.
package snake_pkg;

  localparam int GRID_SIZE = 15;
  localparam int MAX_LEN   = 225;
  localparam int PTR_W     = 8;
  localparam int CELL_W    = 8;

  typedef enum logic [1:0] {
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CALC,
    CHECK,
    UPDATE,
    APPLE,
    OVER
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_t;

  function automatic logic [CELL_W-1:0] cell_idx(
    input logic [3:0] x,
    input logic [3:0] y
  );
    return CELL_W'(x) * CELL_W'(GRID_SIZE) + CELL_W'(y);
  endfunction

  function automatic cell_t idx_cell(input logic [CELL_W-1:0] idx);
    return cell_t'({4'(idx / 8'(GRID_SIZE)), 4'(idx % 8'(GRID_SIZE))});
  endfunction

  function automatic dir_t opp(input dir_t d);
    dir_t r;
    unique case (d)
      UP:    r = DOWN;
      DOWN:  r = UP;
      LEFT:  r = RIGHT;
      RIGHT: r = LEFT;
    endcase
    return r;
  endfunction

  // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells, oldest (tail) to newest (head).
// Sync write, async read of the cell behind the tail.
module snake_body_fifo
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  cell_t            init_cell,
  input  logic             push,
  input  cell_t            din,
  input  logic             pop,
  output cell_t            tail_nxt,
  output logic [PTR_W-1:0] length
);

  cell_t            mem [MAX_LEN];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slot 0 (initial tail) is never read; the tail lives in a register.
  always_ff @(posedge clk) begin
    if (init) begin
      mem[1] <= init_cell;
    end else if (push) begin
      mem[wrap_inc(head_ptr)] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_ptr <= '0;
      head_ptr <= PTR_W'(1);
      length   <= PTR_W'(2);
    end else if (init) begin
      tail_ptr <= '0;
      head_ptr <= PTR_W'(1);
      length   <= PTR_W'(2);
    end else begin
      if (push) head_ptr <= wrap_inc(head_ptr);
      if (pop) tail_ptr <= wrap_inc(tail_ptr);
      if (push && !pop) begin
        length <= length + 1'b1;
      end else if (pop && !push) begin
        length <= length - 1'b1;
      end
    end
  end

  assign tail_nxt = mem[wrap_inc(tail_ptr)];

endmodule

// File: rtl/snake_game_engine.sv
// Snake game-state controller: move FSM, direction latch,
// occupancy vector and LFSR apple placement.
module snake_game_engine
  import snake_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [3:0]         head_x,
  output logic [3:0]         head_y,
  output logic [3:0]         tail_x,
  output logic [3:0]         tail_y,
  output logic [3:0]         apple_x,
  output logic [3:0]         apple_y,
  output logic [MAX_LEN-1:0] cell_snake_vec,
  output logic [7:0]         score,
  output logic               game_over,
  output logic               won
);

  localparam cell_t HEAD0 = cell_t'({4'd7, 4'd7});
  localparam cell_t TAIL0 = cell_t'({4'd6, 4'd7});
  localparam cell_t APPL0 = cell_t'({4'd10, 4'd4});
  localparam logic [3:0] LAST = 4'(GRID_SIZE - 1);
  localparam logic [MAX_LEN-1:0] INIT_VEC =
    (MAX_LEN'(1) << cell_idx(4'd7, 4'd7)) |
    (MAX_LEN'(1) << cell_idx(4'd6, 4'd7));

  state_t             state, state_n;
  dir_t               pend_dir, cur_dir, btn_dir;
  cell_t              head, tail, apple, nxt, nxt_c, tail_nxt;
  logic [MAX_LEN-1:0] vec;
  logic [7:0]         lfsr, srch_cnt, scan_idx;
  logic [PTR_W-1:0]   length;
  logic [CELL_W-1:0]  nxt_idx, tail_idx;
  logic               eat, eat_c, hit_c, btn_any;
  logic               init, ok, give_up, full;

  assign init     = start && (state == IDLE || state == OVER);
  assign nxt_idx  = cell_idx(nxt.x, nxt.y);
  assign tail_idx = cell_idx(tail.x, tail.y);
  assign eat_c    = (nxt == apple);
  assign hit_c    = vec[nxt_idx] && !(nxt == tail && !eat_c);
  assign ok       = (lfsr < 8'(MAX_LEN)) && !vec[lfsr];
  assign give_up  = (srch_cnt == 8'd254);
  assign full     = (length == PTR_W'(MAX_LEN - 1));
  assign btn_any  = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    btn_dir = pend_dir;
    priority case (1'b1)
      btn_up:    btn_dir = UP;
      btn_down:  btn_dir = DOWN;
      btn_left:  btn_dir = LEFT;
      btn_right: btn_dir = RIGHT;
      default:   btn_dir = pend_dir;
    endcase
  end

  always_comb begin
    nxt_c = head;
    unique case (pend_dir)
      UP:    nxt_c.y = (head.y == 4'd0) ? LAST : head.y - 4'd1;
      DOWN:  nxt_c.y = (head.y == LAST) ? 4'd0 : head.y + 4'd1;
      LEFT:  nxt_c.x = (head.x == 4'd0) ? LAST : head.x - 4'd1;
      RIGHT: nxt_c.x = (head.x == LAST) ? 4'd0 : head.x + 4'd1;
    endcase
  end

  // Fallback after an exhausted LFSR period: lowest free cell.
  always_comb begin
    scan_idx = '0;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (!vec[i]) scan_idx = 8'(i);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = RUN;
      RUN:    if (tick) state_n = CALC;
      CALC:   state_n = CHECK;
      CHECK:  state_n = hit_c ? OVER : UPDATE;
      UPDATE: begin
        if (eat) state_n = full ? OVER : APPLE;
        else     state_n = RUN;
      end
      APPLE:  if (ok || give_up) state_n = RUN;
      OVER:   if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dir  <= RIGHT;
      cur_dir   <= RIGHT;
      head      <= HEAD0;
      tail      <= TAIL0;
      apple     <= APPL0;
      nxt       <= HEAD0;
      eat       <= 1'b0;
      vec       <= INIT_VEC;
      score     <= '0;
      game_over <= 1'b0;
      won       <= 1'b0;
      lfsr      <= LFSR_SEED;
      srch_cnt  <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (btn_any && btn_dir != opp(cur_dir)) pend_dir <= btn_dir;
      unique case (state)
        CALC: begin
          cur_dir <= pend_dir;
          nxt     <= nxt_c;
        end
        CHECK: begin
          eat <= eat_c;
          if (hit_c) game_over <= 1'b1;
        end
        UPDATE: begin
          head     <= nxt;
          srch_cnt <= '0;
          // Set after clear so a tail chase keeps the cell occupied.
          if (!eat) vec[tail_idx] <= 1'b0;
          vec[nxt_idx] <= 1'b1;
          if (eat) begin
            if (score != 8'hFF) score <= score + 8'd1;
            if (full) begin
              game_over <= 1'b1;
              won       <= 1'b1;
            end
          end else begin
            tail <= tail_nxt;
          end
        end
        APPLE: begin
          srch_cnt <= srch_cnt + 8'd1;
          if (ok)           apple <= idx_cell(lfsr);
          else if (give_up) apple <= idx_cell(scan_idx);
        end
        default: ;
      endcase
      if (init) begin
        pend_dir  <= RIGHT;
        cur_dir   <= RIGHT;
        head      <= HEAD0;
        tail      <= TAIL0;
        apple     <= APPL0;
        nxt       <= HEAD0;
        eat       <= 1'b0;
        vec       <= INIT_VEC;
        score     <= '0;
        game_over <= 1'b0;
        won       <= 1'b0;
        lfsr      <= LFSR_SEED;
        srch_cnt  <= '0;
      end
    end
  end

  snake_body_fifo u_body (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .init_cell (HEAD0),
    .push      (state == UPDATE),
    .din       (nxt),
    .pop       (state == UPDATE && !eat),
    .tail_nxt  (tail_nxt),
    .length    (length)
  );

  assign head_x         = head.x;
  assign head_y         = head.y;
  assign tail_x         = tail.x;
  assign tail_y         = tail.y;
  assign apple_x        = apple.x;
  assign apple_y        = apple.y;
  assign cell_snake_vec = vec;

endmodule

// File: tb/tb_snake_game_engine.sv
// Randomized bench for snake_game_engine against a queue-based
// model of the snake, its apple and the move rules.
module tb_snake_game_engine;

  localparam int G = 15;
  localparam int N = 225;
  localparam int D_UP = 0;
  localparam int D_DN = 1;
  localparam int D_LT = 2;
  localparam int D_RT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic [3:0] head_x, head_y, tail_x, tail_y, apple_x, apple_y;
  logic [N-1:0] cell_snake_vec;
  logic [7:0] score;
  logic game_over, won;

  int n_chk = 0;
  int n_err = 0;
  int body[$];
  int m_apple, m_score, m_cur, m_pend;
  bit m_over, m_won, did_rst;
  logic [7:0] m_lfsr = 8'hA5;

  snake_game_engine dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .start          (start),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .head_x         (head_x),
    .head_y         (head_y),
    .tail_x         (tail_x),
    .tail_y         (tail_y),
    .apple_x        (apple_x),
    .apple_y        (apple_y),
    .cell_snake_vec (cell_snake_vec),
    .score          (score),
    .game_over      (game_over),
    .won            (won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nb(input int c, input int d);
    int x = c / G;
    int y = c % G;
    case (d)
      D_UP:    y = (y + G - 1) % G;
      D_DN:    y = (y + 1) % G;
      D_LT:    x = (x + G - 1) % G;
      default: x = (x + 1) % G;
    endcase
    return x * G + y;
  endfunction

  function automatic bit occ(input int c);
    foreach (body[i]) if (body[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] mvec();
    logic [N-1:0] v = '0;
    foreach (body[i]) v[body[i]] = 1'b1;
    return v;
  endfunction

  function automatic int first_free();
    for (int c = 0; c < N; c++) if (!occ(c)) return c;
    return 0;
  endfunction

  function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic [3:0] dmask(input int d);
    logic [3:0] m = 4'b1000;
    return m >> d;
  endfunction

  function automatic int ccw(input int d);
    case (d)
      D_RT:    return D_UP;
      D_UP:    return D_LT;
      D_LT:    return D_DN;
      default: return D_RT;
    endcase
  endfunction

  task automatic model_init();
    body.delete();
    body.push_back(7 * G + 7);
    body.push_back(6 * G + 7);
    m_apple = 10 * G + 4;
    m_score = 0;
    m_cur = D_RT;
    m_pend = D_RT;
    m_over = 1'b0;
    m_won = 1'b0;
  endtask

  task automatic step(input bit do_init = 1'b0);
    @(posedge clk);
    if (rst || do_init) m_lfsr = 8'hA5;
    else m_lfsr = lfsr_nx(m_lfsr);
    #1;
  endtask

  task automatic check_all(input string tg);
    int h = body[0];
    int t = body[body.size() - 1];
    chk({tg, ".hx"}, 256'(head_x), 256'(h / G));
    chk({tg, ".hy"}, 256'(head_y), 256'(h % G));
    chk({tg, ".tx"}, 256'(tail_x), 256'(t / G));
    chk({tg, ".ty"}, 256'(tail_y), 256'(t % G));
    chk({tg, ".ax"}, 256'(apple_x), 256'(m_apple / G));
    chk({tg, ".ay"}, 256'(apple_y), 256'(m_apple % G));
    chk({tg, ".sc"}, 256'(score), 256'(m_score));
    chk({tg, ".go"}, 256'(game_over), 256'(m_over));
    chk({tg, ".won"}, 256'(won), 256'(m_won));
    chk({tg, ".vec"}, 256'(cell_snake_vec), 256'(mvec()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_lfsr = 8'hA5;
    model_init();
    check_all("rst");
    step();
    rst = 1'b0;
    check_all("rst2");
  endtask

  task automatic start_game();
    start = 1'b1;
    step(1'b1);
    start = 1'b0;
    model_init();
    check_all("start");
  endtask

  task automatic press(input logic [3:0] m);
    int d;
    {btn_up, btn_down, btn_left, btn_right} = m;
    step();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    d = m[3] ? D_UP : m[2] ? D_DN : m[1] ? D_LT : D_RT;
    if (m != 4'b0 && d != (m_cur ^ 1)) m_pend = d;
  endtask

  task automatic do_tick(input bit rst_apple);
    int n, t;
    bit eat, hit;
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_cur = m_pend;
    n = nb(body[0], m_cur);
    t = body[body.size() - 1];
    eat = (n == m_apple);
    hit = occ(n) && !(n == t && !eat);
    tick = 1'($urandom_range(0, 1));
    step();
    tick = 1'($urandom_range(0, 1));
    step();
    tick = 1'b0;
    if (hit) begin
      m_over = 1'b1;
      chk("hit", 256'(game_over), 256'(1));
      step();
      check_all("over");
      return;
    end
    step();
    body.push_front(n);
    if (eat) m_score = (m_score < 255) ? m_score + 1 : 255;
    else void'(body.pop_back());
    if (eat && body.size() == N) begin
      m_over = 1'b1;
      m_won = 1'b1;
    end
    check_all("mv");
    if (!eat || m_over) return;
    if (rst_apple) begin
      did_rst = 1'b1;
      do_reset();
      return;
    end
    for (int i = 0; i < 255; i++) begin
      int c = int'(m_lfsr);
      tick = 1'($urandom_range(0, 1));
      if (c < N && !occ(c)) begin
        m_apple = c;
        step();
        break;
      end
      if (i == 254) begin
        m_apple = first_free();
        step();
        break;
      end
      step();
    end
    tick = 1'b0;
    check_all("apl");
    chk("apl.free", 256'(cell_snake_vec[apple_x * 4'(G) + apple_y]), 256'(0));
  endtask

  task automatic nav_eat(input bit rst_apple);
    int s0 = m_score;
    int hx, hy, ax, ay, d;
    did_rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (m_over || did_rst || m_score != s0) break;
      hx = body[0] / G;
      hy = body[0] % G;
      ax = m_apple / G;
      ay = m_apple % G;
      if (ax > hx) d = D_RT;
      else if (ax < hx) d = D_LT;
      else if (ay > hy) d = D_DN;
      else d = D_UP;
      if (d == (m_cur ^ 1)) d = (m_cur >= D_LT) ? D_UP : D_LT;
      if (d != m_cur) press(dmask(d));
      do_tick(rst_apple);
    end
  endtask

  task automatic square(input int n);
    for (int k = 0; k < n; k++) begin
      if (m_over) break;
      press(dmask(ccw(m_cur)));
      do_tick(1'b0);
    end
  endtask

  task automatic frozen();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      press(4'($urandom_range(1, 15)));
    end
    tick = 1'b0;
    step();
    check_all("frz");
  endtask

  initial begin
    int r;
    model_init();
    do_reset();
    start_game();
    repeat (3) do_tick(1'b0);
    do_reset();
    start_game();
    press(dmask(D_UP));
    repeat (3) do_tick(1'b0);
    press(dmask(D_RT));
    repeat (3) do_tick(1'b0);
    chk("t2.score", 256'(score), 256'(1));
    nav_eat(1'b0);
    square(8);
    nav_eat(1'b0);
    square(8);
    chk("coll.go", 256'(game_over), 256'(m_over));
    if (m_over) begin
      frozen();
      start_game();
    end else begin
      do_reset();
      start_game();
    end
    repeat (8) do_tick(1'b0);
    press(dmask(D_UP));
    repeat (8) do_tick(1'b0);
    press(dmask(D_DN));
    do_tick(1'b0);
    press(dmask(D_RT));
    do_tick(1'b0);
    press(dmask(D_LT));
    do_tick(1'b0);
    press(4'b1100);
    do_tick(1'b0);
    nav_eat(1'b1);
    if (!did_rst) do_reset();
    start_game();
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        nav_eat(1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) press(4'($urandom_range(1, 15)));
        do_tick(1'b0);
      end
      if (m_over) begin
        frozen();
        start_game();
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
